apb_fifo_slave: RTL

APB responder peripheral sitting on one M_PSELx slot of the APB interconnect. It exposes a DATA_WIDTH-wide FIFO to the cores: a DATA write pushes, a DATA read pops, and STATUS/CTRL registers report and control the FIFO. PREADY is driven after a parameterised number of wait states, so the interconnect's PREADY demux and arbitration paths are exercised.

---
 rtl/apb_fifo_slave_pkg.sv | 24 ++
 rtl/apb_fifo_slave_if.sv | 25 ++
 rtl/fifo_sync.sv | 72 +++++++
 rtl/apb_fifo_slave.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/apb_fifo_slave_pkg.sv
// Shared definitions for the APB FIFO responder: register offsets, STATUS bit map, FSM states.
package apb_fifo_slave_pkg;

   localparam logic [1:0] APB_FIFO_REG_DATA   = 2'd0;
   localparam logic [1:0] APB_FIFO_REG_STATUS = 2'd1;
   localparam logic [1:0] APB_FIFO_REG_CTRL   = 2'd2;
   localparam logic [1:0] APB_FIFO_REG_THRESH = 2'd3;

   localparam int unsigned StatusOverflowBit  = 12;
   localparam int unsigned StatusUnderflowBit = 13;
   localparam int unsigned StatusFullBit      = 14;
   localparam int unsigned StatusEmptyBit     = 15;

   typedef enum logic [0:0] {
      StIdle,
      StAccess
   } apb_state_e;

   // Count spans 0..depth inclusive, so it needs one bit more than a pointer.
   function automatic int unsigned count_width(int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/apb_fifo_slave_if.sv
// APB bus bundle between the interconnect slot (master) and the FIFO responder (slave).
interface apb_fifo_slave_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16
);

   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PWRITE;
   logic                  PSEL;
   logic                  PENABLE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;

   modport master (
      output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
      output PRDATA, PREADY
   );

endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO; push when full and pop when empty are ignored, flush empties it.
module fifo_sync #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PtrOne    = PW'(1);
   localparam logic [PW:0]   CountOne  = (PW + 1)'(1);
   localparam logic [PW:0]   CountFull = (PW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CountFull);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB responder exposing a FIFO through DATA/STATUS/CTRL registers with configurable wait states.
// Define APB_FIFO_SLAVE_IRQ_EN to add the THRESH register and the level irq output.
module apb_fifo_slave
   import apb_fifo_slave_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   apb_fifo_slave_if.slave   apb
`ifdef APB_FIFO_SLAVE_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam int unsigned CW = count_width(DEPTH);
   localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

   apb_state_e            state_q, state_d;
   logic [3:0]            wait_q, wait_d;
   logic                  pready_q, pready_d;
   logic                  fire;
   logic [1:0]            reg_sel;
   logic [DATA_WIDTH-1:0] head;
   logic [CW-1:0]         count;
   logic                  full, empty;
   logic                  push, pop, flush;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   logic [DATA_WIDTH-1:0] status, prdata;
   logic                  unused_paddr;

   // Upper address bits were decoded by the interconnect.
   assign reg_sel      = apb.PADDR[1:0];
   assign unused_paddr = ^apb.PADDR[ADDR_WIDTH-1:0];

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      pready_d = 1'b0;
      fire     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (apb.PSEL && !apb.PENABLE) begin
               wait_d   = WaitInit;
               pready_d = (WaitInit == 4'd0);
               state_d  = StAccess;
            end
         end
         StAccess: begin
            if (!apb.PSEL) begin
               state_d = StIdle;
            end else if (pready_q) begin
               fire    = 1'b1;
               state_d = StIdle;
            end else if (apb.PENABLE) begin
               wait_d   = wait_q - 4'd1;
               pready_d = (wait_q == 4'd1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         wait_q   <= '0;
         pready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         pready_q <= pready_d;
      end
   end

   assign push  = fire & apb.PWRITE & (reg_sel == APB_FIFO_REG_DATA);
   assign pop   = fire & ~apb.PWRITE & (reg_sel == APB_FIFO_REG_DATA);
   assign flush = fire & apb.PWRITE & (reg_sel == APB_FIFO_REG_CTRL) & apb.PWDATA[0];

   fifo_sync #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (apb.PWDATA),
      .head_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (flush) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else begin
         if (push && full)  ovf_d = 1'b1;
         if (pop && empty)  unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   always_comb begin
      status                     = '0;
      status[CW-1:0]             = count;
      status[StatusOverflowBit]  = ovf_q;
      status[StatusUnderflowBit] = unf_q;
      status[StatusFullBit]      = full;
      status[StatusEmptyBit]     = empty;
   end

`ifdef APB_FIFO_SLAVE_IRQ_EN
   logic [CW-1:0] thresh_q, thresh_d;
   logic          irq_q, irq_d;

   always_comb begin
      thresh_d = thresh_q;
      if (fire && apb.PWRITE && (reg_sel == APB_FIFO_REG_THRESH)) begin
         thresh_d = apb.PWDATA[CW-1:0];
      end
      irq_d = (thresh_q != '0) && (count >= thresh_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         thresh_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         thresh_q <= thresh_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

   // Read data shows pre-pop state; the pop itself lands on the same edge PREADY drops.
   always_comb begin
      prdata = '0;
      if (pready_q) begin
         unique case (reg_sel)
            APB_FIFO_REG_DATA:   prdata = empty ? '0 : head;
            APB_FIFO_REG_STATUS: prdata = status;
            APB_FIFO_REG_CTRL:   prdata = '0;
            APB_FIFO_REG_THRESH: begin
`ifdef APB_FIFO_SLAVE_IRQ_EN
               prdata[CW-1:0] = thresh_q;
`else
               prdata = '0;
`endif
            end
            default: prdata = '0;
         endcase
      end
   end

   assign apb.PRDATA = prdata;
   assign apb.PREADY = pready_q;

endmodule
